// File: rtl/print_uart.sv
// print_uart: word FIFO feeding an 8N1 UART transmitter, bytes sent LSB-byte first.
// Define PRINT_SKIP_NULL_EN to suppress frames for 8'h00 bytes.
module print_uart #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        start,
  input  logic        print_en,
  input  logic [31:0] print_data,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  if (DIV < 2) begin : g_div_chk
    $error("print_uart: CLK_FREQ / BAUD_RATE must be >= 2");
  end

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp;
  logic          empty, full, pop, push;
  logic [31:0]   head;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [31:0]   shreg;
  logic          last;

  logic [31:0]   cand;
  logic          more;
  logic [1:0]    skip;
  logic [1:0]    base;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = (state == S_IDLE) && !empty;
  assign push  = print_en && (!full || pop);
  assign head  = mem[rp[AW-1:0]];
  assign last  = (cnt == CW'(DIV - 1));
  assign base  = (state == S_IDLE) ? 2'd0 : byte_idx + 2'd1;

  // cand holds the next byte to send in [7:0]; shifted-in zeros mark the end
  always_comb begin
    cand = (state == S_IDLE) ? head : shreg;
    skip = 2'd0;
`ifdef PRINT_SKIP_NULL_EN
    more = (cand != 32'd0);
    if (cand[7:0] != 8'd0)
      skip = 2'd0;
    else if (cand[15:8] != 8'd0)
      skip = 2'd1;
    else if (cand[23:16] != 8'd0)
      skip = 2'd2;
    else
      skip = 2'd3;
`else
    more = (state == S_IDLE) || (byte_idx != 2'd3);
`endif
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wp[AW-1:0]] <= print_data;
  end

  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      wp       <= '0;
      rp       <= '0;
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= !empty || (state != S_IDLE);
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      if (print_en && full && !pop)
        overflow <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (pop && more) begin
            shreg    <= cand >> {skip, 3'b000};
            byte_idx <= base + skip;
            cnt      <= '0;
            tx       <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (last) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (last) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (last) begin
            cnt <= '0;
            if (more) begin
              shreg    <= cand >> {skip, 3'b000};
              byte_idx <= base + skip;
              tx       <= 1'b0;
              state    <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_print_uart.sv
// tb_print_uart: queue/timing reference model feeds a scoreboard of expected frames;
// a serial monitor decodes tx sample-by-sample and checks shape and start cycle.
module tb_print_uart;

  localparam int CF    = 16;
  localparam int BR    = 4;
  localparam int DEPTH = 4;
  localparam int D     = CF / BR;
`ifdef PRINT_SKIP_NULL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        print_en = 1'b0;
  logic [31:0] print_data = '0;
  logic        tx, busy, overflow;

  print_uart #(
    .CLK_FREQ(CF),
    .BAUD_RATE(BR),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .start(start),
    .print_en(print_en),
    .print_data(print_data),
    .tx(tx),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  b;
    logic [31:0] t;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          free_edge = 0;
  int          last_pop = -1;
  bit          ovf_exp = 1'b0;
  bit          rx_act = 1'b0;
  logic [31:0] mq[$];
  exp_t        expq[$];

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    if ($urandom_range(0, 9) == 0)
      w = 32'h0;
    return w;
  endfunction

  // reference model: word queue plus the cycle the line becomes free
  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    int          n;
    forever begin
      @(posedge clk);
      cyc++;
      if (!start) begin
        mq.delete();
        expq.delete();
        free_edge = 0;
        ovf_exp = 1'b0;
      end else begin
        if (mq.size() > 0 && cyc >= free_edge) begin
          w = mq.pop_front();
          n = 0;
          for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            if (!SKIP || b != 8'h00) begin
              expq.push_back('{b: b, t: 32'(cyc + n * 10 * D)});
              n++;
            end
          end
          free_edge = cyc + n * 10 * D + 1;
          last_pop = cyc;
        end
        if (print_en) begin
          if (mq.size() < DEPTH)
            mq.push_back(print_data);
          else
            ovf_exp = 1'b1;
        end
      end
    end
  end

  // serial monitor: 40 samples per frame, one per cycle
  initial begin
    int         j;
    bit         bad, unexp;
    logic       want;
    logic [7:0] gotb;
    exp_t       e;
    j = 0; bad = 0; unexp = 0; gotb = '0; e = '0;
    forever begin
      @(negedge clk);
      if (!start) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (tx === 1'b0) begin
          rx_act = 1'b1;
          j = 1;
          bad = 1'b0;
          gotb = '0;
          if (expq.size() == 0) begin
            unexp = 1'b1;
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            unexp = 1'b0;
            e = expq.pop_front();
            chk("frame_start_cycle", cyc, e.t);
          end
        end
      end else begin
        if (j < 4)
          want = 1'b0;
        else if (j < 36)
          want = e.b[(j-4)/4];
        else
          want = 1'b1;
        if (j >= 4 && j < 36 && (j % 4) == 2)
          gotb[(j-4)/4] = tx;
        if (tx !== want)
          bad = 1'b1;
        j++;
        if (j == 40) begin
          rx_act = 1'b0;
          if (!unexp) begin
            checks++;
            if (bad) begin
              failures++;
              $display("FAIL frame: got byte %h want byte %h (or bit timing wrong)", gotb, e.b);
            end
          end
        end
      end
    end
  end

  task automatic drive(input bit en, input logic [31:0] d);
    @(negedge clk);
    print_en = en;
    print_data = d;
  endtask

  task automatic clear_model();
    mq.delete();
    expq.delete();
    free_edge = 0;
    ovf_exp = 1'b0;
    rx_act = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (k < 20000 && !(mq.size() == 0 && cyc >= free_edge &&
                          expq.size() == 0 && !rx_act)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done"}, 32'(k < 20000), 32'd1);
    @(negedge clk);
    chk({tag, "_tx_idle"}, 32'(tx), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'(ovf_exp));
  endtask

  initial begin
    int k;
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    start = 1'b1;

    // single word, two printable bytes then two nulls
    drive(1'b1, 32'h0000_4241);
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("busy_high", 32'(busy), 32'd1);
    wait_idle("word4241");

    // burst of six into a depth-4 FIFO: sixth is dropped
    for (int i = 0; i < 6; i++)
      drive(1'b1, 32'hA1B2_C3D0 + 32'(i));
    drive(1'b0, 32'h0);
    wait_idle("burst");
    chk("overflow_set", 32'(overflow), 32'd1);
    drive(1'b1, 32'h3332_3130);
    drive(1'b0, 32'h0);
    wait_idle("after_ovf");
    chk("overflow_sticky", 32'(overflow), 32'd1);

    @(negedge clk);
    start = 1'b0;
    clear_model();
    @(negedge clk);
    chk("rst_clears_overflow", 32'(overflow), 32'd0);
    start = 1'b1;

    // fill the FIFO, then push on the very cycle the idle pop frees a slot
    for (int i = 0; i < 5; i++)
      drive(1'b1, 32'h7060_5040 + 32'(i));
    drive(1'b0, 32'h0);
    k = 0;
    while (k < 2000 && cyc + 1 < free_edge) begin
      @(negedge clk);
      k++;
    end
    chk("full_pop_wait", 32'(k < 2000), 32'd1);
    print_en = 1'b1;
    print_data = 32'h5A5A_A5A5;
    @(negedge clk);
    print_en = 1'b0;
    chk("full_pop_push_no_ovf", 32'(overflow), 32'd0);
    wait_idle("full_pop_push");

    // asynchronous reset during data bit 3 of byte 1
    drive(1'b1, 32'h55AA_C3F0);
    drive(1'b0, 32'h0);
    @(negedge clk);
    k = 0;
    while (k < 2000 && cyc < last_pop + 14 * D + 1) begin
      @(negedge clk);
      k++;
    end
    chk("mid_frame_wait", 32'(k < 2000), 32'd1);
    #1 start = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    clear_model();
    @(negedge clk);
    start = 1'b1;
    print_en = 1'b1;
    print_data = 32'h0A0D_6968;
    @(negedge clk);
    print_en = 1'b0;
    wait_idle("post_reset_word");

    // random words with random gaps
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, rand_word());
      drive(1'b0, 32'h0);
      repeat ($urandom_range(0, 200)) drive(1'b0, 32'h0);
    end
    wait_idle("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/print_uart.md
PRINT_UART -- requirements
Module: print_uart

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, core clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bits/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, word capacity of the print FIFO; power of two, >=2.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port start  input  1  reset, asynchronous, active-low; low clears all state.
REQ-006 SHALL have port print_en  input  1  one-cycle strobe: print_data valid this cycle.
REQ-007 SHALL have port print_data  input  32  word to transmit.
REQ-008 SHALL have port tx  output  1  UART serial line, 8N1, idle high, registered.
REQ-009 SHALL have port busy  output  1  high while FIFO non-empty or a frame is in flight.
REQ-010 SHALL have port overflow  output  1  sticky: a print_en word was dropped.

Function
REQ-011 SHALL derive DIV = CLK_FREQ / BAUD_RATE (integer truncation); DIV < 2 SHALL be a elaboration-time error.
REQ-012 SHALL push print_data into the FIFO on every clk edge where print_en=1 and the FIFO is not full.
REQ-013 SHALL accept a push when full if a pop occurs in the same cycle; occupancy unchanged.
REQ-014 SHALL drop the word when print_en=1, FIFO full and no same-cycle pop, and set overflow=1 until reset.
REQ-015 SHALL implement states IDLE, START, DATA, STOP plus a 2-bit byte index and 3-bit bit index.
REQ-016 IDLE: if FIFO non-empty, SHALL pop the head word into a 32-bit shift register, set byte index 0, go to START next cycle; else stay, tx=1.
REQ-017 SHALL transmit the word as 4 bytes, byte 0 (bits [7:0]) first, byte 3 last; each byte LSB first.
REQ-018 START SHALL drive tx=0 for exactly DIV cycles, then DATA.
REQ-019 DATA SHALL drive each of 8 bits for exactly DIV cycles, then STOP.
REQ-020 STOP SHALL drive tx=1 for exactly DIV cycles; then START of next byte if byte index <3, else IDLE.
REQ-021 A full word SHALL therefore occupy 40*DIV cycles of line time, with IDLE lasting at least one cycle between words.
REQ-022 busy SHALL be registered and equal (FIFO non-empty OR state != IDLE) as of the previous edge.
REQ-023 print_en SHALL never be back-pressured; no ready signal exists.
REQ-024 Pointer wrap SHALL use log2(FIFO_DEPTH)+1-bit pointers; full/empty from MSB comparison.

Reset
REQ-025 start=0 SHALL asynchronously force tx=1, busy=0, overflow=0, state=IDLE, FIFO empty, all counters 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately with tx=1; the aborted and queued words are discarded.
REQ-027 After start rises, the first print_en on the following edge SHALL be accepted normally.

Configuration
REQ-028 With macro PRINT_SKIP_NULL_EN defined, bytes equal to 8'h00 SHALL be skipped (no frame, zero line time); a word of all zero bytes SHALL pop and return to IDLE with tx=1 throughout.
REQ-029 Without PRINT_SKIP_NULL_EN, all 4 bytes SHALL be sent regardless of value.

Verification
REQ-030 CLK_FREQ=16, BAUD_RATE=4 (DIV=4); one print_en with 32'h0000_4241 -> tx frames 0x41,0x42,0x00,0x00, 160 line cycles, busy falls after IDLE reached.
REQ-031 Same config, PRINT_SKIP_NULL_EN defined, 32'h0000_4241 -> only frames 0x41,0x42, 80 line cycles.
REQ-032 FIFO_DEPTH=4; 6 consecutive print_en while first word popped -> 5 words sent in order, 6th dropped, overflow=1 and stays 1.
REQ-033 Push on the exact cycle FIFO is full and IDLE pops -> word accepted, overflow stays 0.
REQ-034 Drive start=0 during DATA bit 3 of byte 1 -> tx=1 same cycle (asynchronous), busy=0, subsequent word 32'h0A0D_6968 transmitted cleanly from byte 0.
REQ-035 Line-timing check: each start bit, data bit, stop bit measured at exactly 4 clk cycles, no gap between consecutive bytes of one word.
